// File: rtl/esm_pkg.sv
// Shared constants for the ESM issue path: instruction buffer sizing, the
// buffer slot record layout, and the dependency-core dimensions.
package esm_pkg;

  localparam int unsigned Instr_word_size = 32;
  // Buffer depth equals the dependency-core table depth; must be a power of two.
  localparam int unsigned bs              = 16;
  localparam int unsigned bs_bits         = $clog2(bs);

  // Dependency-core constants.
  localparam int unsigned DepNumRegs      = 32;
  localparam int unsigned DepRegIdxBits   = $clog2(DepNumRegs);

  // One buffer slot as held by the instruction buffer.
  typedef struct packed {
    logic                       valid;
    logic [Instr_word_size-1:0] instr;
    logic                       alusrc;
    logic                       regwrite;
  } slot_t;

endpackage

// File: rtl/esm_instr_buffer_if.sv
// Handshake bundle between the instruction buffer, its upstream decoder,
// the dependency core and the downstream issue consumer.
interface esm_instr_buffer_if
  import esm_pkg::*;
#(
  parameter int unsigned Instr_word_size = esm_pkg::Instr_word_size,
  parameter int unsigned bs              = esm_pkg::bs
);
  localparam int unsigned bs_bits = $clog2(bs);

  logic                       in_valid;
  logic                       in_ready;
  logic [Instr_word_size-1:0] in_instr;
  logic                       in_alusrc;
  logic                       in_regwrite;

  logic [bs_bits-1:0]         buffer_index;
  logic                       buffer_we;

  logic [bs_bits-1:0]         core_ready_index;
  logic                       core_ready_valid;

  logic                       out_valid;
  logic                       out_ready;
  logic [Instr_word_size-1:0] out_instr;
  logic                       out_alusrc;
  logic                       out_regwrite;
  logic [bs_bits-1:0]         out_index;

  logic [bs_bits:0]           count;
  logic                       full;
  logic                       empty;

  // Environment side: upstream, dependency core and downstream consumer.
  modport master (
    output in_valid, in_instr, in_alusrc, in_regwrite,
    output core_ready_index, core_ready_valid,
    output out_ready,
    input  in_ready, buffer_index, buffer_we,
    input  out_valid, out_instr, out_alusrc, out_regwrite, out_index,
    input  count, full, empty
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_instr, in_alusrc, in_regwrite,
    input  core_ready_index, core_ready_valid,
    input  out_ready,
    output in_ready, buffer_index, buffer_we,
    output out_valid, out_instr, out_alusrc, out_regwrite, out_index,
    output count, full, empty
  );

endinterface

// File: rtl/esm_free_slot_enc.sv
// Lowest-index priority encoder over the buffer free mask.
module esm_free_slot_enc
  import esm_pkg::*;
#(
  parameter int unsigned bs = esm_pkg::bs,
  localparam int unsigned bs_bits = $clog2(bs)
) (
  input  logic [bs-1:0]      free_mask,
  output logic [bs_bits-1:0] index,
  output logic               any_free
);

  // Scan from the top so the lowest free slot is the last assignment to win.
  always_comb begin
    index    = '0;
    any_free = 1'b0;
    for (int i = int'(bs) - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        index    = bs_bits'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/esm_instr_buffer.sv
// Out-of-order instruction buffer: allocates the lowest free slot for each
// incoming instruction and issues whichever slot the dependency core reports
// as dependency-free into a single output register.
module esm_instr_buffer
  import esm_pkg::*;
#(
  parameter int unsigned Instr_word_size = esm_pkg::Instr_word_size,
  parameter int unsigned bs              = esm_pkg::bs,
  localparam int unsigned bs_bits        = $clog2(bs)
) (
  input  logic               clk,
  input  logic               rst_n,
  esm_instr_buffer_if.slave  bus
);

  localparam logic [bs_bits:0] CountMax = (bs_bits + 1)'(bs);
  localparam logic [bs_bits:0] CountOne = (bs_bits + 1)'(1);

  logic [bs-1:0]              valid_q, valid_d;
  logic [Instr_word_size-1:0] instr_q [bs];
  logic [bs-1:0]              alusrc_q;
  logic [bs-1:0]              regwrite_q;

  logic [bs_bits:0]           count_q, count_d;

  logic                       out_valid_q;
  logic [Instr_word_size-1:0] out_instr_q;
  logic                       out_alusrc_q;
  logic                       out_regwrite_q;
  logic [bs_bits-1:0]         out_index_q;

  logic [bs-1:0]              free_mask;
  logic [bs_bits-1:0]         enc_index;
  logic                       any_free;
  logic [bs_bits-1:0]         alloc_idx;
  logic                       full;
  logic                       empty;
  logic                       accept;
  logic                       candidate;
  logic                       load;

  esm_free_slot_enc #(
    .bs (bs)
  ) u_free_slot_enc (
    .free_mask (free_mask),
    .index     (enc_index),
    .any_free  (any_free)
  );

  // Allocation, issue decision and next-state for occupancy.
  always_comb begin
    free_mask = ~valid_q;
    alloc_idx = any_free ? enc_index : '0;
    full      = (count_q == CountMax);
    empty     = (count_q == '0);
    accept    = bus.in_valid && !full;
    candidate = bus.core_ready_valid && valid_q[bus.core_ready_index];
    load      = candidate && (!out_valid_q || bus.out_ready);

    // Accept and load never target the same slot: one is free, the other valid.
    valid_d = valid_q;
    if (accept) valid_d[alloc_idx] = 1'b1;
    if (load)   valid_d[bus.core_ready_index] = 1'b0;

    count_d = count_q;
    if (accept && !load)      count_d = count_q + CountOne;
    else if (!accept && load) count_d = count_q - CountOne;
  end

  // Slot valid bits and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // Slot payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (accept) begin
      instr_q[alloc_idx]    <= bus.in_instr;
      alusrc_q[alloc_idx]   <= bus.in_alusrc;
      regwrite_q[alloc_idx] <= bus.in_regwrite;
    end
  end

  // Issue register: loads a ready slot, holds while stalled, drains on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_instr_q    <= '0;
      out_alusrc_q   <= 1'b0;
      out_regwrite_q <= 1'b0;
      out_index_q    <= '0;
    end else if (load) begin
      out_valid_q    <= 1'b1;
      out_instr_q    <= instr_q[bus.core_ready_index];
      out_alusrc_q   <= alusrc_q[bus.core_ready_index];
      out_regwrite_q <= regwrite_q[bus.core_ready_index];
      out_index_q    <= bus.core_ready_index;
    end else if (bus.out_ready) begin
      out_valid_q    <= 1'b0;
    end
  end

  assign bus.in_ready     = !full;
  assign bus.buffer_index = alloc_idx;
  assign bus.buffer_we    = accept;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_instr    = out_instr_q;
  assign bus.out_alusrc   = out_alusrc_q;
  assign bus.out_regwrite = out_regwrite_q;
  assign bus.out_index    = out_index_q;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;

endmodule

// File: tb/tb_esm_instr_buffer.sv
// Directed bench for esm_instr_buffer with a slot model and an issue scoreboard.
module tb_esm_instr_buffer;

  logic clk;
  logic rst_n;

  esm_instr_buffer_if bus ();

  esm_instr_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        alu;
    logic        rw;
    logic [3:0]  idx;
  } out_t;

  int          errors = 0;
  int          checks = 0;
  logic        m_valid [16];
  logic [31:0] m_instr [16];
  logic        m_alu   [16];
  logic        m_rw    [16];
  int          m_count;
  logic        m_ov;
  out_t        last_out;
  out_t        sb [$];
  int          saved;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 16; i++) if (!m_valid[i]) return i;
    return 0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_count  = 0;
    m_ov     = 1'b0;
    last_out = '0;
    sb.delete();
  endtask

  task automatic idle_inputs();
    bus.in_valid         = 1'b0;
    bus.in_instr         = '0;
    bus.in_alusrc        = 1'b0;
    bus.in_regwrite      = 1'b0;
    bus.core_ready_valid = 1'b0;
    bus.core_ready_index = '0;
    bus.out_ready        = 1'b0;
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check state.
  task automatic cyc(input logic v, input logic [31:0] w, input logic a, input logic r,
                     input logic crv, input logic [3:0] cri, input logic ordy);
    int   exp_idx;
    logic acc, ld;
    bus.in_valid         = v;
    bus.in_instr         = w;
    bus.in_alusrc        = a;
    bus.in_regwrite      = r;
    bus.core_ready_valid = crv;
    bus.core_ready_index = cri;
    bus.out_ready        = ordy;
    #1;
    exp_idx = lowest_free();
    acc     = v && (m_count != 16);
    ld      = crv && m_valid[cri] && (!m_ov || ordy);
    check("buffer_index", 64'(bus.buffer_index), 64'(exp_idx));
    check("buffer_we", 64'(bus.buffer_we), 64'(acc));
    check("in_ready", 64'(bus.in_ready), 64'(m_count != 16));
    @(posedge clk);
    if (ld) begin
      sb.push_back('{instr: m_instr[cri], alu: m_alu[cri], rw: m_rw[cri], idx: cri});
      m_valid[cri] = 1'b0;
    end
    if (acc) begin
      m_valid[exp_idx] = 1'b1;
      m_instr[exp_idx] = w;
      m_alu[exp_idx]   = a;
      m_rw[exp_idx]    = r;
    end
    m_count = m_count + int'(acc) - int'(ld);
    if (ld)        m_ov = 1'b1;
    else if (ordy) m_ov = 1'b0;
    #1;
    check("count", 64'(bus.count), 64'(m_count));
    check("full", 64'(bus.full), 64'(m_count == 16));
    check("empty", 64'(bus.empty), 64'(m_count == 0));
    check("out_valid", 64'(bus.out_valid), 64'(m_ov));
    if (ld) begin
      last_out = sb.pop_front();
      check("out_instr", 64'(bus.out_instr), 64'(last_out.instr));
      check("out_alusrc", 64'(bus.out_alusrc), 64'(last_out.alu));
      check("out_regwrite", 64'(bus.out_regwrite), 64'(last_out.rw));
      check("out_index", 64'(bus.out_index), 64'(last_out.idx));
    end else if (m_ov) begin
      check("hold_instr", 64'(bus.out_instr), 64'(last_out.instr));
      check("hold_index", 64'(bus.out_index), 64'(last_out.idx));
      check("hold_ctrl", 64'({bus.out_alusrc, bus.out_regwrite}),
            64'({last_out.alu, last_out.rw}));
    end
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    model_clear();
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_buffer_index", 64'(bus.buffer_index), 64'd0);
    check("rst_buffer_we", 64'(bus.buffer_we), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_instr", 64'(bus.out_instr), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_clear();
    #3;
    reset_dut();

    // Three accepts land in slots 0, 1, 2.
    cyc(1'b1, 32'hA, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    cyc(1'b1, 32'hC, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    check("three_count", 64'(bus.count), 64'd3);

    // Slots 0-3 full, issue slot 2, refill goes to slot 2.
    cyc(1'b1, 32'hD, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1);
    check("issue_word", 64'(bus.out_instr), 64'hC);
    check("issue_index", 64'(bus.out_index), 64'd2);
    bus.in_valid = 1'b1;
    #1;
    check("refill_slot", 64'(bus.buffer_index), 64'd2);
    cyc(1'b1, 32'hE, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

    // Stall: out_ready low, ready reports must not load.
    saved = int'(bus.count);
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    check("stall_count", 64'(bus.count), 64'(saved));
    check("stall_word", 64'(bus.out_instr), 64'hC);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    // Ready report for an empty slot is ignored.
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd15, 1'b1);
    check("empty_report_ov", 64'(bus.out_valid), 64'd0);

    // Fill to 16, then a 17th request is refused.
    for (int i = 0; i < 20 && m_count < 16; i++)
      cyc(1'b1, 32'h100 + 32'(i), i[0], i[1], 1'b0, 4'd0, 1'b0);
    check("fill_full", 64'(bus.full), 64'd1);
    check("fill_in_ready", 64'(bus.in_ready), 64'd0);
    cyc(1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    check("overflow_count", 64'(bus.count), 64'd16);

    // Drop to 15, then accept and issue together.
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
    cyc(1'b1, 32'hF00D, 1'b1, 1'b0, 1'b1, 4'd7, 1'b1);
    check("acc_issue_count", 64'(bus.count), 64'd15);
    check("acc_issue_ov", 64'(bus.out_valid), 64'd1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    bus.in_valid = 1'b1;
    #1;
    check("freed_slot_next", 64'(bus.buffer_index), 64'd7);
    bus.in_valid = 1'b0;

    // Async reset mid-stream with count=7 and out_valid=1.
    reset_dut();
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h200 + 32'(i), 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
    check("pre_rst_count", 64'(bus.count), 64'd7);
    check("pre_rst_ov", 64'(bus.out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_count", 64'(bus.count), 64'd0);
    check("async_ov", 64'(bus.out_valid), 64'd0);
    check("async_empty", 64'(bus.empty), 64'd1);
    check("async_out_index", 64'(bus.out_index), 64'd0);
    reset_dut();
    cyc(1'b1, 32'h55, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
